// File: rtl/hs_pkg.sv
// hs_pkg: shared definitions for the Snake high-score path.
//   - default score width and apple value
//   - game-phase state encoding used by highscore_ctrl
package hs_pkg;

  localparam int unsigned ScoreWDefault   = 13;
  localparam int unsigned ApplePtsDefault = 10;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StPaused = 3'd2,
    StOver   = 3'd3,
    StCommit = 3'd4,
    StDone   = 3'd5
  } hs_state_e;

endpackage

// File: rtl/hs_sat_add.sv
// hs_sat_add: unsigned W-bit adder that clamps at 2^W-1 instead of wrapping.
// Ports:
//   a, b : addends
//   sum  : min(a + b, 2^W-1)
module hs_sat_add #(
  parameter int unsigned W = 13
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sum  = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/highscore_ctrl.sv
// highscore_ctrl: game-phase sequencer for the Snake high-score path.
// Runs the IDLE/RUN/PAUSED/OVER/COMMIT/DONE state machine, holds the elapsed
// timer outside of active play, accumulates apple points and commits the
// final score into a high-score register at game over.
//
// Build option: define HS_TIME_BONUS_EN to add time_in to the score in OVER.
// Without it time_in is ignored.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : pulse, begin a new game (IDLE/DONE only)
//   pause      : pulse, toggle RUN <-> PAUSED
//   collision  : pulse, snake died (RUN/PAUSED -> OVER)
//   apple      : pulse, apple eaten (counted in RUN only)
//   time_in    : elapsed-time count from the timer
//   timer_hold : 1 whenever the game is not actively running
//   playing    : state is RUN
//   game_over  : state is DONE
//   score      : running / committed score
//   high_score : best committed score since reset
//   new_record : last commit strictly beat the previous high score
module highscore_ctrl
  import hs_pkg::*;
#(
  parameter int unsigned SCORE_W   = ScoreWDefault,
  parameter int unsigned APPLE_PTS = ApplePtsDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               collision,
  input  logic               apple,
  input  logic [SCORE_W-1:0] time_in,
  output logic               timer_hold,
  output logic               playing,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record
);

  localparam logic [SCORE_W-1:0] AppleInc = SCORE_W'(APPLE_PTS);

  hs_state_e          state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic               rec_q, rec_d;
  logic [SCORE_W-1:0] add_b;
  logic [SCORE_W-1:0] add_sum;

  // One shared adder: apple increment while running, time bonus in OVER.
`ifdef HS_TIME_BONUS_EN
  assign add_b = (state_q == StOver) ? time_in : AppleInc;
`else
  logic unused_time_in;
  assign unused_time_in = ^time_in;
  assign add_b          = AppleInc;
`endif

  hs_sat_add #(
    .W (SCORE_W)
  ) u_sat_add (
    .a   (score_q),
    .b   (add_b),
    .sum (add_sum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Collision always outranks pause.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (collision)  state_d = StOver;
        else if (pause) state_d = StPaused;
      end
      StPaused: begin
        if (collision)  state_d = StOver;
        else if (pause) state_d = StRun;
      end
      StOver:   state_d = StCommit;
      StCommit: state_d = StDone;
      StDone: begin
        if (start) state_d = StRun;
      end
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    playing    = (state_q == StRun);
    game_over  = (state_q == StDone);
    timer_hold = (state_q != StRun);
  end

  // Score / high-score datapath next-state.
  always_comb begin
    score_d = score_q;
    high_d  = high_q;
    rec_d   = rec_q;
    unique case (state_q)
      StIdle: score_d = '0;
      StRun: begin
        // Apple is counted even when collision ends the game this cycle.
        if (apple) score_d = add_sum;
      end
      StOver: begin
`ifdef HS_TIME_BONUS_EN
        score_d = add_sum;
`endif
      end
      StCommit: begin
        if (score_q > high_q) begin
          high_d = score_q;
          rec_d  = 1'b1;
        end else begin
          rec_d  = 1'b0;
        end
      end
      StDone: begin
        if (start) begin
          score_d = '0;
          rec_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= '0;
      high_q  <= '0;
      rec_q   <= 1'b0;
    end else begin
      score_q <= score_d;
      high_q  <= high_d;
      rec_q   <= rec_d;
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign new_record = rec_q;

endmodule

// File: tb/tb_highscore_ctrl.sv
// Testbench for highscore_ctrl: directed table, corner sequences, and random
// stimulus checked against an event-level game model.
module tb_highscore_ctrl;

  localparam int SW   = 13;
  localparam int MAXS = (1 << SW) - 1;
  localparam int PTS  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, pause = 1'b0, collision = 1'b0, apple = 1'b0;
  logic [SW-1:0] time_in = '0;
  logic          timer_hold, playing, game_over, new_record;
  logic [SW-1:0] score, high_score;

  highscore_ctrl #(
    .SCORE_W   (SW),
    .APPLE_PTS (PTS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .collision  (collision),
    .apple      (apple),
    .time_in    (time_in),
    .timer_hold (timer_hold),
    .playing    (playing),
    .game_over  (game_over),
    .score      (score),
    .high_score (high_score),
    .new_record (new_record)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit playing;
    bit game_over;
    bit timer_hold;
    int score;
    int high_score;
    bit new_record;
  } outs_t;

  typedef struct {
    bit    s, p, c, a;
    outs_t e;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Game model: flags for "in a game" and "paused", a countdown for the
  // two-cycle end-of-game sequence, and plain integer scores.
  bit m_live, m_paused, m_over, m_rec;
  int m_cd, m_score, m_hs;

  function automatic int sat(int v);
    return (v > MAXS) ? MAXS : v;
  endfunction

  function automatic void model_reset();
    m_live = 0; m_paused = 0; m_over = 0; m_rec = 0;
    m_cd = 0; m_score = 0; m_hs = 0;
  endfunction

  function automatic void model_step(bit s, bit p, bit c, bit a, int t);
    if (m_cd == 2) begin
`ifdef HS_TIME_BONUS_EN
      m_score = sat(m_score + t);
`endif
      m_cd = 1;
    end else if (m_cd == 1) begin
      m_rec = (m_score > m_hs);
      if (m_rec) m_hs = m_score;
      m_cd = 0;
      m_over = 1;
    end else if (m_live && !m_paused) begin
      if (a) m_score = sat(m_score + PTS);
      if (c) begin m_live = 0; m_cd = 2; end
      else if (p) m_paused = 1;
    end else if (m_live) begin
      if (c) begin m_live = 0; m_paused = 0; m_cd = 2; end
      else if (p) m_paused = 0;
    end else if (s) begin
      if (m_over) begin m_score = 0; m_rec = 0; end
      m_over = 0; m_live = 1; m_paused = 0;
    end
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    o.playing    = m_live && !m_paused;
    o.game_over  = m_over;
    o.timer_hold = !(m_live && !m_paused);
    o.score      = m_score;
    o.high_score = m_hs;
    o.new_record = m_rec;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input outs_t e);
    chk({tag, " playing"},    32'(playing),    32'(e.playing));
    chk({tag, " game_over"},  32'(game_over),  32'(e.game_over));
    chk({tag, " timer_hold"}, 32'(timer_hold), 32'(e.timer_hold));
    chk({tag, " score"},      32'(score),      32'(e.score));
    chk({tag, " high_score"}, 32'(high_score), 32'(e.high_score));
    chk({tag, " new_record"}, 32'(new_record), 32'(e.new_record));
  endtask

  // One clock: drive, take the edge, update the model, settle.
  task automatic cyc(input bit s, input bit p, input bit c, input bit a, input int t);
    start = s; pause = p; collision = c; apple = a; time_in = SW'(t);
    @(posedge clk);
    model_step(s, p, c, a, t);
    #1;
    start = 0; pause = 0; collision = 0; apple = 0;
  endtask

  task automatic do_reset();
    start = 0; pause = 0; collision = 0; apple = 0; time_in = '0;
    rst = 0;
    model_reset();
    #1;
    chk_outs("reset", model_outs());
    @(negedge clk);
    rst = 1;
  endtask

  function automatic vec_t mk(bit s, bit p, bit c, bit a,
                              bit pl, bit go, bit th, int sc, int hs, bit nr);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.a = a;
    v.e.playing = pl; v.e.game_over = go; v.e.timer_hold = th;
    v.e.score = sc; v.e.high_score = hs; v.e.new_record = nr;
    return v;
  endfunction

  vec_t tbl[$];
  outs_t e0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //               s  p  c  a   pl go th  sc  hs nr
    // Game 1: three apples, first record.
    tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 10,  0, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 20,  0, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 30,  0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  0, 0, 1, 30,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 1, 30,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 1, 30, 30, 1));
    // Game 2: lower score.
    tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0,  0, 30, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 10, 30, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 20, 30, 0));
    tbl.push_back(mk(0, 0, 1, 0,  0, 0, 1, 20, 30, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 1, 20, 30, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 1, 20, 30, 0));
    // Game 3: tie.
    tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0,  0, 30, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 10, 30, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 20, 30, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 30, 30, 0));
    tbl.push_back(mk(0, 0, 1, 0,  0, 0, 1, 30, 30, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 1, 30, 30, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 1, 30, 30, 0));
    // Pause: apples ignored, start in RUN ignored, apple+collision counted.
    tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0,  0, 30, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 1,  0, 30, 0));
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 1,  0, 30, 0));
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 1,  0, 30, 0));
    tbl.push_back(mk(0, 1, 0, 0,  1, 0, 0,  0, 30, 0));
    tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0,  0, 30, 0));
    tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 10, 30, 0));
    tbl.push_back(mk(0, 0, 1, 1,  0, 0, 1, 20, 30, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 1, 20, 30, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 1, 20, 30, 0));
    // pause+collision in RUN -> OVER.
    tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0,  0, 30, 0));
    tbl.push_back(mk(0, 1, 1, 0,  0, 0, 1,  0, 30, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 1,  0, 30, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 1,  0, 30, 0));
    // start ignored in PAUSED, pause+collision in PAUSED -> OVER.
    tbl.push_back(mk(1, 0, 0, 0,  1, 0, 0,  0, 30, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 1,  0, 30, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 1,  0, 30, 0));
    tbl.push_back(mk(0, 1, 1, 0,  0, 0, 1,  0, 30, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 1,  0, 30, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 1,  0, 30, 0));

    // Reset values as fixed constants.
    rst = 0;
    #2;
    e0.playing = 0; e0.game_over = 0; e0.timer_hold = 1;
    e0.score = 0; e0.high_score = 0; e0.new_record = 0;
    chk_outs("por", e0);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].a, 0);
      chk_outs($sformatf("tbl[%0d]", i), tbl[i].e);
    end

    // Saturation: 819 apples reach 8190, the next clamps at 8191.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    repeat (819) cyc(0, 0, 0, 1, 0);
    chk("sat 8190", 32'(score), 32'd8190);
    cyc(0, 0, 0, 1, 0);
    chk("sat 8191", 32'(score), 32'(MAXS));
    cyc(0, 0, 0, 1, 0);
    chk("sat hold", 32'(score), 32'(MAXS));
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("sat hs", 32'(high_score), 32'(MAXS));
    chk("sat rec", 32'(new_record), 32'd1);
    chk("sat done", 32'(game_over), 32'd1);

    // Time bonus: 5 apples, time_in=100 at game over.
    do_reset();
    cyc(1, 0, 0, 0, 100);
    repeat (5) cyc(0, 0, 0, 1, 100);
    cyc(0, 0, 1, 0, 100);
    cyc(0, 0, 0, 0, 100);
    cyc(0, 0, 0, 0, 100);
`ifdef HS_TIME_BONUS_EN
    chk("bonus score", 32'(score), 32'd150);
    chk("bonus hs", 32'(high_score), 32'd150);
`else
    chk("nobonus score", 32'(score), 32'd50);
    chk("nobonus hs", 32'(high_score), 32'd50);
`endif
    chk("bonus done", 32'(game_over), 32'd1);

    // Asynchronous reset while in COMMIT with high_score=30.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pre hs", 32'(high_score), 32'd30);
    cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("commit hold", 32'(timer_hold), 32'd1);
    chk("commit hs", 32'(high_score), 32'd30);
    #2;
    rst = 0;
    model_reset();
    #1;
    chk_outs("rst in commit", e0);
    @(negedge clk);
    rst = 1;
    cyc(0, 0, 0, 0, 0);
    chk_outs("idle after rst", e0);

    // Random play against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
          int'($urandom_range(0, MAXS)));
      chk_outs($sformatf("rnd[%0d]", i), model_outs());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/highscore_ctrl.md
# highscore_ctrl

Game-phase sequencer for the Snake high-score path. Owns the run/pause/over state machine, drives the hold input of the elapsed-time counter, accumulates the running score from apple events and commits it to a high-score register at game over. Sits between the game-logic pulses (start, pause, collision, apple) and the score display and high-score datapath.

## Interface
- SCORE_W, 13: width of score, high score and time input
- APPLE_PTS, 10: points added per apple event
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begin a new game
- pause  in  1  one-cycle pulse, toggle pause
- collision  in  1  one-cycle pulse, snake died
- apple  in  1  one-cycle pulse, apple eaten
- time_in  in  SCORE_W  elapsed-time count from the timer
- timer_hold  out  1  1 = timer held at zero/frozen; drives the timer's active-high enable-to-clear
- playing  out  1  state is RUN
- game_over  out  1  state is DONE
- score  out  SCORE_W  running/committed score
- high_score  out  SCORE_W  best committed score since reset
- new_record  out  1  last commit strictly beat previous high_score

## Operation
- States: IDLE, RUN, PAUSED, OVER, COMMIT, DONE (encoding in package).
- IDLE: timer_hold=1, score=0. start -> RUN.
- RUN: timer_hold=0. apple adds APPLE_PTS to score. pause -> PAUSED. collision -> OVER. start ignored.
- PAUSED: timer_hold=1; score frozen; apple ignored. pause -> RUN. collision -> OVER. start ignored.
- OVER (1 cycle): timer_hold=1; optional time bonus applied (see Configuration). -> COMMIT.
- COMMIT (1 cycle): if score > high_score: high_score<=score, new_record<=1; else new_record<=0. -> DONE.
- DONE: game_over=1; score and new_record held. start -> RUN with score<=0, new_record<=0.
- Arithmetic: all additions saturate at 2^SCORE_W-1; never wrap.
- Simultaneous events in RUN: apple is counted, then collision wins over pause (RUN -> OVER, pause dropped). In PAUSED, collision wins over pause.
- Tie on commit: high_score unchanged, new_record=0.
- Reset (any time, including mid-game or mid-COMMIT): state IDLE, timer_hold=1, score=0, high_score=0, new_record=0, playing=0, game_over=0. High score does not survive reset.

## Timing
- All outputs registered or decoded from registered state; no input-to-output combinational path.
- start sampled at edge N: state=RUN and timer_hold=0 after edge N.
- apple at edge N: score updated after edge N.
- collision at edge N: OVER after N, COMMIT after N+1, DONE with high_score/new_record valid after N+2.
- timer_hold rises after the same edge that enters PAUSED or OVER; time_in sampled in OVER is stable.

## Configuration
- HS_TIME_BONUS_EN defined: in OVER, score <= sat(score + time_in).
- Undefined: OVER adds nothing; score is apple points only; time_in unused.

## Structure
- Package hs_pkg: state encoding constants, default SCORE_W, APPLE_PTS.
- One sub-module: hs_sat_add (SCORE_W-wide saturating adder), used for apple and time-bonus additions.

## Test plan
- Reset, start, 3 apples, collision -> score=30, high_score=30, new_record=1, game_over=1 three cycles after collision.
- Second game: start, 2 apples, collision -> score=20, high_score=30, new_record=0; third game 3 apples -> tie, high_score=30, new_record=0.
- pause, apple x2, pause, apple -> score=10, timer_hold=1 only while PAUSED; start during RUN ignored.
- score preloaded near max via 819 apples (8190) then 1 apple -> score=8191 saturated; with HS_TIME_BONUS_EN, time_in=100 at game over with 5 apples -> score=150.
- Same-cycle apple+collision -> score +10 then OVER; same-cycle pause+collision -> OVER, not PAUSED.
- rst asserted in COMMIT with high_score=30 -> all outputs zero, state IDLE, timer_hold=1.
